spi_dac_receiver: RTL and testbench
===================================

// Module: spi_dac_receiver
// PURPOSE
// - SPI responder modelling the MCP4911 DAC input side: the receiving end of the DAC programming link (bLDAC/bCS/SCK/SDI).
// - Oversamples the SPI pins on clk, shifts in one MSB-first word per bCS frame and latches it into an input register.
// - Transfers the input register to the DAC output register on bLDAC; used in-fabric as loopback checker and DAC stand-in.
// PARAMETERS
// - spi_length   16  bits per frame; must be >= dac_bits+4
// - dac_bits     10  DAC code width, word[spi_length-5 -: dac_bits]
// - sync_stages  2   synchroniser flops on each SPI pin, >= 2
// PORTS
// - clk          in   1               system clock, the only clock
// - rst          in   1               synchronous, active-high reset
// - bCS          in   1               chip select bar, async to clk
// - SCK          in   1               serial clock, async; sampled on rising edge
// - SDI          in   1               serial data into this block
// - bLDAC        in   1               load-DAC bar, async
// - rx_data      out  spi_length      last accepted word (input register)
// - rx_valid     out  1               1-cycle pulse: new word accepted
// - frame_err    out  1               1-cycle pulse: frame bit count != spi_length
// - cmd_ignored  out  1               1-cycle pulse: full frame with MSB=1 (not a DAC write)
// - dac_code     out  dac_bits        DAC output register code
// - dac_buf      out  1               word bit spi_length-2 (BUF)
// - dac_gain_x1  out  1               word bit spi_length-3 (GA bar: 1 = 1x gain)
// - dac_active   out  1               word bit spi_length-4 (SHDN bar)
// - dac_update   out  1               1-cycle pulse: DAC output register loaded
// - busy         out  1               high while a frame is open (state S_SHIFT)
// BEHAVIOUR
// - Sync: each pin passes through sync_stages flops, plus one delay flop for edge detect.
// - Sync chains reset to idle levels: bCS=1, bLDAC=1, SCK=0, SDI=0.
// - Latency: a pin edge produces its registered output effect sync_stages+1 clk cycles after its first sampling edge.
// - Timing requirement: SCK high and low phases >= sync_stages+1 clk cycles each; SDI stable across the SCK rising edge.
// - Reset: all outputs 0, state S_IDLE, shift reg and bit_cnt 0.
// - FSM S_IDLE: on synced bCS falling edge, clear shift reg and bit_cnt, then go to S_SHIFT. SCK edges are ignored.
// - FSM S_SHIFT: on each synced SCK rising edge, shift_reg <= {shift_reg, SDI}. bit_cnt saturates at spi_length+1.
// - S_SHIFT exit: on synced bCS rising edge, evaluate the frame and return to S_IDLE.
// - Frame evaluation, bit_cnt != spi_length: frame_err pulse; rx_data unchanged.
// - Frame evaluation, bit_cnt == spi_length and MSB=1: cmd_ignored pulse; rx_data unchanged.
// - Frame evaluation, bit_cnt == spi_length and MSB=0: rx_data <= shift reg; rx_valid pulse.
// - SCK rising and bCS rising detected in the same cycle: the SCK edge is dropped; the frame is evaluated on existing bits.
// - After reset with bCS already low: no frame opens until a bCS falling edge is seen.
// - DAC transfer triggers on either of:
//   (a) synced bLDAC falling edge;
//   (b) bLDAC synced low in the cycle a word is accepted.
// - DAC transfer action: load dac_code, dac_buf, dac_gain_x1, dac_active from the input register; pulse dac_update.
// - Word acceptance and transfer in the same cycle: the newly accepted word goes to the DAC outputs; one dac_update pulse.
// - bLDAC falling while busy: transfers the previous rx_data; the open frame is unaffected.
// - Pulse outputs are registered and high for exactly one cycle. DAC outputs hold until the next transfer or rst.
// TESTING
// - Frame 16'h3FFC, then bLDAC low pulse:
//   rx_valid once, rx_data=16'h3FFC, no dac_update before bLDAC;
//   then dac_code=10'h3FF, dac_buf=0, dac_gain_x1=1, dac_active=1.
// - 15-bit frame, then 17-bit frame: frame_err pulses twice; rx_valid never; rx_data and dac_* unchanged.
// - Frame 16'hB000: cmd_ignored pulse; rx_valid=0; rx_data holds its prior value.
// - bLDAC held low, frame 16'h7004: rx_valid and dac_update in the same cycle; dac_code=10'h001, dac_buf=1, gain_x1=1, active=1.
// - rst asserted after 8 bits of a frame: all outputs 0, busy=0.
//   Then a full frame 16'h1554 gives rx_valid with rx_data=16'h1554.
// - SCK toggled 20x with bCS high, plus SCK edge coincident with bCS rise: no pulses; the 16-bit frame is still accepted.

Source files
------------

// File: rtl/spi_dac_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : spi_dac_receiver
//  Description : SPI responder modelling the MCP4911 DAC input side.
//                Oversamples bCS/SCK/SDI/bLDAC on clk, shifts in one
//                MSB-first word per bCS frame, latches accepted DAC-write
//                words into an input register and transfers the input
//                register to the DAC output register on bLDAC.
//  Ports       : clk, rst          - system clock, synchronous active-high reset
//                bCS, SCK, SDI     - SPI pins, asynchronous to clk
//                bLDAC             - load-DAC bar, asynchronous to clk
//                rx_data/rx_valid  - input register and new-word pulse
//                frame_err         - pulse: frame bit count wrong
//                cmd_ignored       - pulse: full frame that is not a DAC write
//                dac_code/dac_buf/dac_gain_x1/dac_active - DAC output register
//                dac_update        - pulse: DAC output register loaded
//                busy              - a frame is open
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_dac_receiver #(
    parameter int SPI_LENGTH  = 16,
    parameter int DAC_BITS    = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bCS,
    input  logic                  SCK,
    input  logic                  SDI,
    input  logic                  bLDAC,
    output logic [SPI_LENGTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  cmd_ignored,
    output logic [DAC_BITS-1:0]   dac_code,
    output logic                  dac_buf,
    output logic                  dac_gain_x1,
    output logic                  dac_active,
    output logic                  dac_update,
    output logic                  busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_CNT_W = $clog2(SPI_LENGTH + 2);
    localparam logic [c_CNT_W-1:0] c_CNT_LEN = c_CNT_W'(SPI_LENGTH);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(SPI_LENGTH + 1);

    localparam int c_SET_W = $clog2(SYNC_STAGES + 2);
    localparam logic [c_SET_W-1:0] c_SET_MAX = c_SET_W'(SYNC_STAGES + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    // ------------------------------------------------------------------------
    // Pin synchronisers. Chains reset to the idle pin levels so that reset
    // release does not by itself fake an edge on a pin that is idle.
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_sdi_sync;
    logic [SYNC_STAGES-1:0] r_ldac_sync;
    logic                   r_cs_d;
    logic                   r_sck_d;
    logic                   r_ldac_d;

    // Post-reset qualification of bCS falling edges
    logic [c_SET_W-1:0]     r_settle;
    logic                   r_cs_armed;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cs_sync   <= {SYNC_STAGES{1'b1}};
            r_sck_sync  <= {SYNC_STAGES{1'b0}};
            r_sdi_sync  <= {SYNC_STAGES{1'b0}};
            r_ldac_sync <= {SYNC_STAGES{1'b1}};
            r_cs_d      <= 1'b1;
            r_sck_d     <= 1'b0;
            r_ldac_d    <= 1'b1;
            r_settle    <= '0;
            r_cs_armed  <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   bCS};
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0],  SCK};
            r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0],  SDI};
            r_ldac_sync <= {r_ldac_sync[SYNC_STAGES-2:0], bLDAC};
            r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
            r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
            r_ldac_d    <= r_ldac_sync[SYNC_STAGES-1];
            if (r_settle != c_SET_MAX) begin
                r_settle <= r_settle + 1'b1;
            end
            // If bCS was already low at reset release, the chain flushing
            // its reset value looks like a falling edge. Only accept falls
            // once the chain has flushed and bCS has been seen high.
            if ((r_settle == c_SET_MAX) && r_cs_sync[SYNC_STAGES-1]) begin
                r_cs_armed <= 1'b1;
            end
        end
    end

    logic w_cs_s;
    logic w_sdi_s;
    logic w_ldac_s;
    logic w_cs_fall;
    logic w_cs_rise;
    logic w_sck_rise;
    logic w_ldac_fall;

    assign w_cs_s      = r_cs_sync[SYNC_STAGES-1];
    assign w_sdi_s     = r_sdi_sync[SYNC_STAGES-1];
    assign w_ldac_s    = r_ldac_sync[SYNC_STAGES-1];
    assign w_cs_fall   = r_cs_d & ~w_cs_s & r_cs_armed;
    assign w_cs_rise   = ~r_cs_d & w_cs_s;
    assign w_sck_rise  = ~r_sck_d & r_sck_sync[SYNC_STAGES-1];
    assign w_ldac_fall = r_ldac_d & ~w_ldac_s;

    // ------------------------------------------------------------------------
    // Frame FSM, shift register and output registers
    // ------------------------------------------------------------------------
    logic [0:0]            r_state;
    logic [SPI_LENGTH-1:0] r_shift;
    logic [c_CNT_W-1:0]    r_bit_cnt;
    logic [SPI_LENGTH-1:0] r_rx_data;
    logic                  r_rx_valid;
    logic                  r_frame_err;
    logic                  r_cmd_ignored;
    logic [DAC_BITS-1:0]   r_dac_code;
    logic                  r_dac_buf;
    logic                  r_dac_gain_x1;
    logic                  r_dac_active;
    logic                  r_dac_update;

    logic w_accept;
    logic w_dac_load;

    // A full-length DAC-write frame closes this cycle
    assign w_accept   = (r_state == S_SHIFT) && w_cs_rise &&
                        (r_bit_cnt == c_CNT_LEN) && !r_shift[SPI_LENGTH-1];
    assign w_dac_load = w_ldac_fall | (w_accept & ~w_ldac_s);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_rx_data     <= '0;
            r_rx_valid    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_cmd_ignored <= 1'b0;
            r_dac_code    <= '0;
            r_dac_buf     <= 1'b0;
            r_dac_gain_x1 <= 1'b0;
            r_dac_active  <= 1'b0;
            r_dac_update  <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_frame_err   <= 1'b0;
            r_cmd_ignored <= 1'b0;
            r_dac_update  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_cs_fall) begin
                        r_shift   <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // bCS rise takes priority: a coincident SCK edge is dropped
                    if (w_cs_rise) begin
                        r_state <= S_IDLE;
                        if (r_bit_cnt != c_CNT_LEN) begin
                            r_frame_err <= 1'b1;
                        end else if (r_shift[SPI_LENGTH-1]) begin
                            r_cmd_ignored <= 1'b1;
                        end else begin
                            r_rx_data  <= r_shift;
                            r_rx_valid <= 1'b1;
                        end
                    end else if (w_sck_rise) begin
                        r_shift <= {r_shift[SPI_LENGTH-2:0], w_sdi_s};
                        // Saturate one past the frame length so over-long
                        // frames stay distinguishable from exact ones
                        if (r_bit_cnt != c_CNT_MAX) begin
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // A word accepted this cycle bypasses the input register so the
            // DAC sees the new word, not the one it replaces
            if (w_dac_load) begin
                r_dac_update <= 1'b1;
                if (w_accept) begin
                    r_dac_code    <= r_shift[SPI_LENGTH-5 -: DAC_BITS];
                    r_dac_buf     <= r_shift[SPI_LENGTH-2];
                    r_dac_gain_x1 <= r_shift[SPI_LENGTH-3];
                    r_dac_active  <= r_shift[SPI_LENGTH-4];
                end else begin
                    r_dac_code    <= r_rx_data[SPI_LENGTH-5 -: DAC_BITS];
                    r_dac_buf     <= r_rx_data[SPI_LENGTH-2];
                    r_dac_gain_x1 <= r_rx_data[SPI_LENGTH-3];
                    r_dac_active  <= r_rx_data[SPI_LENGTH-4];
                end
            end
        end
    end

    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_err   = r_frame_err;
    assign cmd_ignored = r_cmd_ignored;
    assign dac_code    = r_dac_code;
    assign dac_buf     = r_dac_buf;
    assign dac_gain_x1 = r_dac_gain_x1;
    assign dac_active  = r_dac_active;
    assign dac_update  = r_dac_update;
    assign busy        = (r_state == S_SHIFT);

endmodule
`default_nettype wire

// File: tb/tb_spi_dac_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_dac_receiver
//  Description : Directed self-checking bench for spi_dac_receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_dac_receiver;

    logic        clk;
    logic        rst;
    logic        bCS;
    logic        SCK;
    logic        SDI;
    logic        bLDAC;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic        cmd_ignored;
    logic [9:0]  dac_code;
    logic        dac_buf;
    logic        dac_gain_x1;
    logic        dac_active;
    logic        dac_update;
    logic        busy;

    spi_dac_receiver #(
        .SPI_LENGTH  (16),
        .DAC_BITS    (10),
        .SYNC_STAGES (2)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .bCS         (bCS),
        .SCK         (SCK),
        .SDI         (SDI),
        .bLDAC       (bLDAC),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .cmd_ignored (cmd_ignored),
        .dac_code    (dac_code),
        .dac_buf     (dac_buf),
        .dac_gain_x1 (dac_gain_x1),
        .dac_active  (dac_active),
        .dac_update  (dac_update),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Pulse counters, sampled mid-cycle
    int n_rx   = 0;
    int n_err  = 0;
    int n_cmd  = 0;
    int n_upd  = 0;
    int n_both = 0;

    always @(negedge clk) begin
        if (rx_valid)               n_rx++;
        if (frame_err)              n_err++;
        if (cmd_ignored)            n_cmd++;
        if (dac_update)             n_upd++;
        if (rx_valid && dac_update) n_both++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Send the low nbits of word MSB-first; optionally raise SCK together
    // with bCS at the end of the frame.
    task automatic send_frame(input logic [31:0] word, input int nbits, input bit coinc);
        bCS = 1'b0;
        wait_clks(6);
        for (int i = nbits - 1; i >= 0; i--) begin
            SDI = word[i];
            wait_clks(4);
            SCK = 1'b1;
            wait_clks(4);
            SCK = 1'b0;
        end
        wait_clks(4);
        bCS = 1'b1;
        if (coinc) SCK = 1'b1;
        wait_clks(8);
        SCK = 1'b0;
        wait_clks(4);
    endtask

    task automatic ldac_pulse();
        bLDAC = 1'b0;
        wait_clks(8);
        bLDAC = 1'b1;
        wait_clks(8);
    endtask

    int s_rx, s_err, s_cmd, s_upd, s_both;

    task automatic snap();
        s_rx   = n_rx;
        s_err  = n_err;
        s_cmd  = n_cmd;
        s_upd  = n_upd;
        s_both = n_both;
    endtask

    initial begin
        rst   = 1'b1;
        bCS   = 1'b1;
        SCK   = 1'b0;
        SDI   = 1'b0;
        bLDAC = 1'b1;
        wait_clks(5);
        check("reset_rx_data",  32'(rx_data), 32'h0);
        check("reset_dac_code", 32'(dac_code), 32'h0);
        check("reset_busy",     32'(busy), 32'h0);
        check("reset_pulses",   32'({rx_valid, frame_err, cmd_ignored, dac_update}), 32'h0);
        check("reset_dac_bits", 32'({dac_buf, dac_gain_x1, dac_active}), 32'h0);
        rst = 1'b0;
        wait_clks(10);

        // Frame 3FFC, then bLDAC pulse
        snap();
        send_frame(32'h3FFC, 16, 1'b0);
        check("w1_rx_count",    32'(n_rx - s_rx), 32'd1);
        check("w1_rx_data",     32'(rx_data), 32'h3FFC);
        check("w1_no_update",   32'(n_upd - s_upd), 32'd0);
        check("w1_dac_held",    32'(dac_code), 32'h0);
        ldac_pulse();
        check("w1_update_cnt",  32'(n_upd - s_upd), 32'd1);
        check("w1_dac_code",    32'(dac_code), 32'h3FF);
        check("w1_dac_bits",    32'({dac_buf, dac_gain_x1, dac_active}), 32'b011);

        // Short and long frames
        snap();
        send_frame(32'h1234, 15, 1'b0);
        send_frame(32'h1ABCD, 17, 1'b0);
        check("len_err_cnt",    32'(n_err - s_err), 32'd2);
        check("len_rx_cnt",     32'(n_rx - s_rx), 32'd0);
        check("len_rx_data",    32'(rx_data), 32'h3FFC);
        check("len_dac_code",   32'(dac_code), 32'h3FF);
        check("len_upd_cnt",    32'(n_upd - s_upd), 32'd0);

        // Non-write command
        snap();
        send_frame(32'hB000, 16, 1'b0);
        check("cmd_cnt",        32'(n_cmd - s_cmd), 32'd1);
        check("cmd_rx_cnt",     32'(n_rx - s_rx), 32'd0);
        check("cmd_rx_data",    32'(rx_data), 32'h3FFC);

        // bLDAC held low: accept and transfer together
        bLDAC = 1'b0;
        wait_clks(8);
        snap();
        send_frame(32'h7004, 16, 1'b0);
        check("ldl_rx_cnt",     32'(n_rx - s_rx), 32'd1);
        check("ldl_upd_cnt",    32'(n_upd - s_upd), 32'd1);
        check("ldl_same_cycle", 32'(n_both - s_both), 32'd1);
        check("ldl_dac_code",   32'(dac_code), 32'h001);
        check("ldl_dac_bits",   32'({dac_buf, dac_gain_x1, dac_active}), 32'b111);
        bLDAC = 1'b1;
        wait_clks(8);

        // Reset in the middle of a frame, bCS still low afterwards
        bCS = 1'b0;
        wait_clks(6);
        for (int i = 0; i < 8; i++) begin
            SDI = i[0];
            wait_clks(4);
            SCK = 1'b1;
            wait_clks(4);
            SCK = 1'b0;
        end
        check("mid_busy",       32'(busy), 32'h1);
        rst = 1'b1;
        wait_clks(3);
        check("rst_rx_data",    32'(rx_data), 32'h0);
        check("rst_dac_code",   32'(dac_code), 32'h0);
        check("rst_dac_bits",   32'({dac_buf, dac_gain_x1, dac_active}), 32'h0);
        check("rst_busy",       32'(busy), 32'h0);
        check("rst_pulses",     32'({rx_valid, frame_err, cmd_ignored, dac_update}), 32'h0);
        rst = 1'b0;
        snap();
        wait_clks(8);
        for (int i = 0; i < 3; i++) begin
            SCK = 1'b1;
            wait_clks(4);
            SCK = 1'b0;
            wait_clks(4);
        end
        check("post_rst_busy",  32'(busy), 32'h0);
        bCS = 1'b1;
        wait_clks(8);
        check("post_rst_err",   32'(n_err - s_err), 32'd0);
        send_frame(32'h1554, 16, 1'b0);
        check("rec_rx_cnt",     32'(n_rx - s_rx), 32'd1);
        check("rec_rx_data",    32'(rx_data), 32'h1554);

        // SCK activity with bCS high, then SCK edge coincident with bCS rise
        snap();
        for (int i = 0; i < 20; i++) begin
            SCK = 1'b1;
            wait_clks(4);
            SCK = 1'b0;
            wait_clks(4);
        end
        check("idle_sck_pulses", 32'((n_rx - s_rx) + (n_err - s_err) + (n_cmd - s_cmd) + (n_upd - s_upd)), 32'd0);
        check("idle_sck_busy",  32'(busy), 32'h0);
        send_frame(32'h2AA8, 16, 1'b1);
        check("coinc_rx_cnt",   32'(n_rx - s_rx), 32'd1);
        check("coinc_err_cnt",  32'(n_err - s_err), 32'd0);
        check("coinc_rx_data",  32'(rx_data), 32'h2AA8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
